uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width of the per-entry "bytes minus one" field; never narrower than one bit.
    function automatic int nbytes_width(input int word_w);
        int w;
        w = $clog2(word_w / 8);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous word FIFO with registered read: pop_data updates on the edge that pops
// and then holds that entry. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pop_data_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_reg == (AW + 1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = pop_data_reg;
    assign level    = level_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (pop_ok) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; each entry sends 1..WORD_W/8 bytes LSB first.
// Define UART_TX_FRAME_CNT_EN to add a 16-bit wrapping count of completed byte frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    localparam int NBW = nbytes_width(WORD_W),
    localparam int LW  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_uart,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [NBW-1:0]    wr_nbytes,
    input  logic              ovf_clr,
    output logic              tx_serial,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic              overflow
`ifdef UART_TX_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int NBYTES = WORD_W / 8;
    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int EW     = NBW + WORD_W;

    tx_state_t         state_reg, state_next;
    logic [CW-1:0]     baud_reg, baud_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [NBW-1:0]    byte_idx_reg, byte_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic              par_reg, par_next;
    logic              tx_reg, tx_next;
    logic              overflow_reg;
    logic              pop;
    logic              bit_done;
    logic [EW-1:0]     head;
    logic [NBW-1:0]    head_nbytes;
    logic [WORD_W-1:0] head_data;
    logic [7:0]        head_bytes [NBYTES];
    logic [7:0]        cur_byte;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_uart),
        .srst      (reset),
        .push      (wr_en),
        .push_data ({wr_nbytes, wr_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // The popped entry stays in the FIFO's read register for the whole transmission.
    assign {head_nbytes, head_data} = head;
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
        assign head_bytes[gi] = head_data[gi*8 +: 8];
    end
    assign cur_byte = head_bytes[byte_idx_reg];
    assign bit_done = (baud_reg == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_uart) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            shift_reg    <= shift_next;
            par_reg      <= par_next;
            tx_reg       <= tx_next;
            if (wr_en && full) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // tx_next is the line level of the current state; the line register adds one cycle.
    always_comb begin
        state_next    = state_reg;
        baud_next     = '0;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        shift_next    = shift_reg;
        par_next      = par_reg;
        tx_next       = 1'b1;
        pop           = 1'b0;
        if (state_reg != ST_IDLE) begin
            baud_next = bit_done ? '0 : baud_reg + 1'b1;
        end
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    byte_idx_next = '0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    shift_next   = cur_byte;
                    par_next     = (PARITY == PAR_ODD) ? ~(^cur_byte) : ^cur_byte;
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_next = shift_reg[0];
                if (bit_done) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                tx_next = par_reg;
                if (bit_done) begin
                    bit_idx_next = '0;
                    state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_idx_reg == 3'(STOP_BITS - 1)) begin
                        bit_idx_next = '0;
                        if (byte_idx_reg < head_nbytes) begin
                            byte_idx_next = byte_idx_reg + 1'b1;
                            state_next    = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign tx_serial = tx_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign overflow  = overflow_reg;

`ifdef UART_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk_uart) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (state_reg == ST_STOP && bit_done && bit_idx_reg == 3'(STOP_BITS - 1)) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: three parity/stop configurations share one stimulus
// stream, each checked every cycle against a queue-based line model.
module tb_uart_tx_fifo;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int CPB    = 4;
    localparam int NBW    = 2;
    localparam int LW     = 3;
    localparam int EW     = NBW + WORD_W;
    localparam int NCFG   = 3;

    function automatic int par_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic int stop_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    logic              clk_uart = 1'b0;
    logic              reset    = 1'b1;
    logic              wr_en    = 1'b0;
    logic [WORD_W-1:0] wr_data  = '0;
    logic [NBW-1:0]    wr_nbytes = '0;
    logic              ovf_clr  = 1'b0;
    bit                chk_en   = 1'b0;
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk_uart = ~clk_uart;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int PAR   = par_of(gi);
        localparam int STB   = stop_of(gi);
        localparam int NSYM  = 1 + 8 + ((PAR != 0) ? 1 : 0) + STB;
        localparam int FRAME = NSYM * CPB;

        logic          tx;
        logic          busy;
        logic          full;
        logic          empty;
        logic [LW-1:0] level;
        logic          overflow;
`ifdef UART_TX_FRAME_CNT_EN
        logic [15:0]   frame_cnt;
`endif

        uart_tx_fifo #(
            .WORD_W       (WORD_W),
            .FIFO_DEPTH   (DEPTH),
            .CLKS_PER_BIT (CPB),
            .PARITY       (PAR),
            .STOP_BITS    (STB)
        ) dut (
            .clk_uart  (clk_uart),
            .reset     (reset),
            .wr_en     (wr_en),
            .wr_data   (wr_data),
            .wr_nbytes (wr_nbytes),
            .ovf_clr   (ovf_clr),
            .tx_serial (tx),
            .busy      (busy),
            .full      (full),
            .empty     (empty),
            .level     (level),
            .overflow  (overflow)
`ifdef UART_TX_FRAME_CNT_EN
            ,
            .frame_cnt (frame_cnt)
`endif
        );

        // Model: pending entries, per-cycle line levels of the frame in flight, and
        // the number of cycles until the transmitter is idle again.
        logic [EW-1:0] q [$];
        bit            line_q [$];
        bit            line_prev = 1'b1;
        bit            exp_tx    = 1'b1;
        bit            exp_ovf   = 1'b0;
        int            busy_cnt  = 0;
        int            fcnt      = 0;

        initial forever begin : model_step
            bit            full_before;
            logic [EW-1:0] ent;
            int            nb;
            logic [7:0]    by;
            bit            v;
            @(posedge clk_uart);
            if (reset) begin
                q.delete();
                line_q.delete();
                line_prev = 1'b1;
                exp_tx    = 1'b1;
                exp_ovf   = 1'b0;
                busy_cnt  = 0;
                fcnt      = 0;
            end else begin
                exp_tx      = line_prev;
                full_before = (q.size() == DEPTH);
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt % FRAME == 0) fcnt = (fcnt + 1) % 65536;
                end else if (q.size() > 0) begin
                    ent      = q.pop_front();
                    nb       = int'(ent[EW-1 -: NBW]) + 1;
                    busy_cnt = nb * FRAME;
                    for (int b = 0; b < nb; b++) begin
                        by = ent[b*8 +: 8];
                        for (int s = 0; s < NSYM; s++) begin
                            if (s == 0) v = 1'b0;
                            else if (s <= 8) v = by[s-1];
                            else if (PAR != 0 && s == 9)
                                v = (PAR == 1) ? ($countones(by) % 2 == 1) : ($countones(by) % 2 == 0);
                            else v = 1'b1;
                            repeat (CPB) line_q.push_back(v);
                        end
                    end
                end
                line_prev = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
                if (wr_en) begin
                    if (full_before) exp_ovf = 1'b1;
                    else q.push_back({wr_nbytes, wr_data});
                end
                if (!(wr_en && full_before) && ovf_clr) exp_ovf = 1'b0;
            end
        end

        initial forever begin : cycle_check
            @(negedge clk_uart);
            if (chk_en) begin
                check($sformatf("c%0d_tx", gi), 32'(tx), 32'(exp_tx));
                check($sformatf("c%0d_busy", gi), 32'(busy), 32'(busy_cnt > 0));
                check($sformatf("c%0d_level", gi), 32'(level), 32'(q.size()));
                check($sformatf("c%0d_full", gi), 32'(full), 32'(q.size() == DEPTH));
                check($sformatf("c%0d_empty", gi), 32'(empty), 32'(q.size() == 0));
                check($sformatf("c%0d_ovf", gi), 32'(overflow), 32'(exp_ovf));
`ifdef UART_TX_FRAME_CNT_EN
                check($sformatf("c%0d_fcnt", gi), 32'(frame_cnt), 32'(fcnt));
`endif
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [NBW-1:0] nb);
        wr_en     = 1'b1;
        wr_data   = d;
        wr_nbytes = nb;
        $display("push data=%08h nbytes=%0d", d, nb);
        @(negedge clk_uart);
        wr_en = 1'b0;
    endtask

    int a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        repeat (3) @(negedge clk_uart);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_tx", 32'(g_cfg[0].tx), 32'd1);
        check("rst_busy", 32'(g_cfg[0].busy), 32'd0);
        check("rst_full", 32'(g_cfg[0].full), 32'd0);
        check("rst_empty", 32'(g_cfg[0].empty), 32'd1);
        check("rst_level", 32'(g_cfg[0].level), 32'd0);
        check("rst_ovf", 32'(g_cfg[0].overflow), 32'd0);

        // Single byte 0xA5 on the no-parity, one-stop-bit instance.
        push(32'h0000_00A5, 2'd0);
        check("a5_idle_n", 32'(g_cfg[0].tx), 32'd1);
        @(negedge clk_uart);
        check("a5_idle_n1", 32'(g_cfg[0].tx), 32'd1);
        @(negedge clk_uart);
        check("a5_fall_n2", 32'(g_cfg[0].tx), 32'd0);
        @(negedge clk_uart);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_bit%0d", k), 32'(g_cfg[0].tx), 32'(a5_bits[k]));
            repeat (4) @(negedge clk_uart);
        end
        check("a5_busy_end", 32'(g_cfg[0].busy), 32'd0);
        repeat (20) @(negedge clk_uart);

        // Four bytes back to back from one entry.
        push(32'h1122_3344, 2'd3);
        repeat (250) @(negedge clk_uart);
`ifdef UART_TX_FRAME_CNT_EN
        check("fcnt_after_5", 32'(g_cfg[0].frame_cnt), 32'd5);
`endif

        // Fill past capacity while the transmitter is stalled on a long entry.
        for (int i = 0; i < 5; i++) push(32'hA000_0000 + 32'(i), 2'd3);
        check("ovf_full5", 32'(g_cfg[0].full), 32'd1);
        check("ovf_none5", 32'(g_cfg[0].overflow), 32'd0);
        push(32'hBEEF_0006, 2'd3);
        check("ovf_set6", 32'(g_cfg[0].overflow), 32'd1);
        check("ovf_level6", 32'(g_cfg[0].level), 32'd4);
        repeat (20) @(negedge clk_uart);
        check("ovf_sticky", 32'(g_cfg[0].overflow), 32'd1);
        ovf_clr = 1'b1;
        push(32'hDEAD_0007, 2'd0);
        ovf_clr = 1'b0;
        check("ovf_clr_vs_drop", 32'(g_cfg[0].overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk_uart);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(g_cfg[0].overflow), 32'd0);
        repeat (1100) @(negedge clk_uart);

        // Reset during data bit 3 (a zero bit of 0x96), then a clean retransmission.
        push(32'h0000_0096, 2'd0);
        repeat (17) @(negedge clk_uart);
        reset = 1'b1;
        @(negedge clk_uart);
        reset = 1'b0;
        check("midrst_tx", 32'(g_cfg[0].tx), 32'd1);
        check("midrst_level", 32'(g_cfg[0].level), 32'd0);
        check("midrst_busy", 32'(g_cfg[0].busy), 32'd0);
        push(32'h0000_55C3, 2'd1);
        repeat (120) @(negedge clk_uart);

        // Random traffic, including occasional resets and overflow clears.
        for (int i = 0; i < 400; i++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_data   = $urandom;
            wr_nbytes = NBW'($urandom_range(0, 3));
            ovf_clr   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            if (wr_en) $display("push data=%08h nbytes=%0d", wr_data, wr_nbytes);
            @(negedge clk_uart);
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        reset   = 1'b0;
        repeat (1300) @(negedge clk_uart);
        check("drain_busy", 32'(g_cfg[1].busy), 32'd0);
        check("drain_empty", 32'(g_cfg[1].empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
